// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and width helper for the round-robin arbiter
package arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational first-set-bit scan of mask starting at start, wrapping modulo N
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = width_of(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);
  logic [IDW-1:0] c;
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = '0;
    for (int k = 0; k < N; k++) begin
      c = IDW'((int'(start) + k) % N);
      if (!any && mask[c]) begin
        any       = 1'b1;
        idx       = c;
        onehot[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter with grant hold and bounded contended hold time
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = width_of(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);
  localparam int CW = width_of(MAX_HOLD + 1);
  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   others, mask, pick_oh;
  logic [IDW-1:0] pick_idx;
  logic           pick_any, release_now, preempt, take;
  assign others      = req & ~gnt;
  assign mask        = (state == ST_GRANT) ? others : req;
  assign release_now = (state == ST_GRANT) && !(|(req & gnt));
  assign preempt     = (state == ST_GRANT) && !release_now && (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD)) && pick_any;
  assign take        = pick_any && ((state == ST_IDLE) || release_now || preempt);
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .mask  (mask),
    .start (ptr),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );
  // a release with others pending hands over directly, so take is tested before release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else if (take) begin
      state     <= ST_GRANT;
      gnt       <= pick_oh;
      gnt_valid <= 1'b1;
      gnt_id    <= pick_idx;
      ptr       <= (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
      cnt       <= CW'(1);
    end else if (release_now) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      cnt       <= '0;
    end else if (state == ST_GRANT && cnt < CW'(MAX_HOLD)) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
